prescaled_stopwatch_timer: RTL and testbench

//  Parametrised stopwatch / countdown timer: next generation of the team's 8-bit timer.

---
 rtl/prescaled_stopwatch_timer_if.sv | 29 ++
 rtl/prescaled_stopwatch_timer.sv | 127 ++++++++++++
 tb/tb_prescaled_stopwatch_timer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/prescaled_stopwatch_timer_if.sv
// Control and status bundle for prescaled_stopwatch_timer; master drives the controls,
// slave (the timer) returns the registered count and status.
interface prescaled_stopwatch_timer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic             auto_reload;
  logic [WIDTH-1:0] load_val;
  logic             lap;
  logic [WIDTH-1:0] time_out;
  logic [WIDTH-1:0] lap_out;
  logic             lap_valid;
  logic             running;
  logic             done;
  logic             overflow;

  modport master (
    output start, stop, clear, mode, auto_reload, load_val, lap,
    input  time_out, lap_out, lap_valid, running, done, overflow
  );

  modport slave (
    input  start, stop, clear, mode, auto_reload, load_val, lap,
    output time_out, lap_out, lap_valid, running, done, overflow
  );
endinterface

// File: rtl/prescaled_stopwatch_timer.sv
// Stopwatch / countdown timer with clock prescaler, pause/resume, lap capture,
// auto-reload countdown and sticky stopwatch overflow. All outputs registered.
module prescaled_stopwatch_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  prescaled_stopwatch_timer_if.slave    tmr
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] time_q;
  logic [WIDTH-1:0] lap_q;
  logic [WIDTH-1:0] reload_q;
  logic [PW-1:0]    pre_q;
  logic             mode_q;
  logic             autorl_q;
  logic             lap_valid_q;
  logic             running_q;
  logic             done_q;
  logic             ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      lap_q       <= '0;
      reload_q    <= '0;
      pre_q       <= '0;
      mode_q      <= 1'b0;
      autorl_q    <= 1'b0;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      lap_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (tmr.clear) begin
        state_q   <= S_IDLE;
        time_q    <= '0;
        pre_q     <= '0;
        ovf_q     <= 1'b0;
        running_q <= 1'b0;
      end else begin
        // Lap captures the count as it stands before this cycle's update.
        if (tmr.lap && (state_q == S_RUN || state_q == S_PAUSE)) begin
          lap_q       <= time_q;
          lap_valid_q <= 1'b1;
        end
        case (state_q)
          S_IDLE, S_DONE: begin
            if (tmr.start) begin
              mode_q   <= tmr.mode;
              autorl_q <= tmr.auto_reload;
              reload_q <= tmr.load_val;
              pre_q    <= '0;
              if (tmr.mode && tmr.load_val == '0) begin
                state_q   <= S_DONE;
                time_q    <= '0;
                done_q    <= 1'b1;
                running_q <= 1'b0;
              end else begin
                state_q   <= S_RUN;
                time_q    <= tmr.mode ? tmr.load_val : '0;
                running_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (tmr.stop) begin
              state_q   <= S_PAUSE;
              running_q <= 1'b0;
            end else if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              if (!mode_q) begin
                if (&time_q) ovf_q  <= 1'b1;
                else         time_q <= time_q + ONE;
              end else if (time_q > ONE) begin
                time_q <= time_q - ONE;
              end else begin
                done_q <= 1'b1;
                if (autorl_q) begin
                  time_q <= reload_q;
                end else begin
                  time_q    <= '0;
                  state_q   <= S_DONE;
                  running_q <= 1'b0;
                end
              end
            end else begin
              pre_q <= pre_q + 1'b1;
            end
          end
          S_PAUSE: begin
            // Resume keeps the held prescaler phase; start+stop together stays paused.
            if (tmr.start && !tmr.stop) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tmr.time_out  = time_q;
  assign tmr.lap_out   = lap_q;
  assign tmr.lap_valid = lap_valid_q;
  assign tmr.running   = running_q;
  assign tmr.done      = done_q;
  assign tmr.overflow  = ovf_q;

endmodule

// File: tb/tb_prescaled_stopwatch_timer.sv
// Randomized bench: two timer instances (8-bit/prescale 4 and 4-bit/prescale 1) share
// stimulus and are compared every cycle against a behavioural cycle model.
module tb_prescaled_stopwatch_timer;

  logic clk;
  logic reset_n;

  prescaled_stopwatch_timer_if #(.WIDTH(8)) ifa ();
  prescaled_stopwatch_timer_if #(.WIDTH(4)) ifb ();

  prescaled_stopwatch_timer #(.WIDTH(8), .PRESCALE(4)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .tmr     (ifa.slave)
  );

  prescaled_stopwatch_timer #(.WIDTH(4), .PRESCALE(1)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .tmr     (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;

  typedef struct {
    int ph;
    int t;
    int lap;
    int lapv;
    int done;
    int ovf;
    int runc;
    int mode;
    int arl;
    int rl;
  } m_t;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic m_t m_reset();
    m_t m;
    m = '{default: 0};
    m.ph = P_IDLE;
    return m;
  endfunction

  // One clock of the timer described by its rules: ticks fall on every PRESCALE-th
  // running cycle counted from the start-accept edge.
  function automatic m_t m_step(m_t m, int w, int ps, bit st, bit sp, bit cl,
                                bit md, bit ar, int lv, bit lp);
    m_t n;
    int maxv;
    n = m;
    maxv = (1 << w) - 1;
    n.lapv = 0;
    n.done = 0;
    if (cl) begin
      n.ph = P_IDLE; n.t = 0; n.ovf = 0; n.runc = 0;
      return n;
    end
    if (lp && (m.ph == P_RUN || m.ph == P_PAUSE)) begin
      n.lap = m.t;
      n.lapv = 1;
    end
    if (m.ph == P_IDLE || m.ph == P_DONE) begin
      if (st) begin
        n.mode = md; n.arl = ar; n.rl = lv; n.runc = 0;
        if (md && lv == 0) begin
          n.ph = P_DONE; n.t = 0; n.done = 1;
        end else begin
          n.ph = P_RUN; n.t = md ? lv : 0;
        end
      end
    end else if (m.ph == P_RUN) begin
      if (sp) n.ph = P_PAUSE;
      else begin
        n.runc = m.runc + 1;
        if (n.runc % ps == 0) begin
          if (m.mode == 0) begin
            if (m.t == maxv) n.ovf = 1;
            else n.t = m.t + 1;
          end else if (m.t > 1) begin
            n.t = m.t - 1;
          end else begin
            n.done = 1;
            if (m.arl != 0) n.t = m.rl;
            else begin n.t = 0; n.ph = P_DONE; end
          end
        end
      end
    end else begin
      if (st && !sp) n.ph = P_RUN;
    end
    return n;
  endfunction

  task automatic chk_dut(string p, m_t m, logic [31:0] t, logic [31:0] l,
                         logic lv, logic rn, logic dn, logic ov);
    check_eq({p, ".time_out"},  t, 32'(m.t));
    check_eq({p, ".lap_out"},   l, 32'(m.lap));
    check_eq({p, ".lap_valid"}, 32'(lv), 32'(m.lapv));
    check_eq({p, ".running"},   32'(rn), (m.ph == P_RUN) ? 32'd1 : 32'd0);
    check_eq({p, ".done"},      32'(dn), 32'(m.done));
    check_eq({p, ".overflow"},  32'(ov), 32'(m.ovf));
  endtask

  task automatic chk_both(m_t ma, m_t mb);
    chk_dut("A", ma, 32'(ifa.time_out), 32'(ifa.lap_out), ifa.lap_valid,
            ifa.running, ifa.done, ifa.overflow);
    chk_dut("B", mb, 32'(ifb.time_out), 32'(ifb.lap_out), ifb.lap_valid,
            ifb.running, ifb.done, ifb.overflow);
  endtask

  task automatic drive(bit st, bit sp, bit cl, bit md, bit ar, int lv, bit lp);
    ifa.start = st; ifa.stop = sp; ifa.clear = cl; ifa.mode = md;
    ifa.auto_reload = ar; ifa.load_val = 8'(lv); ifa.lap = lp;
    ifb.start = st; ifb.stop = sp; ifb.clear = cl; ifb.mode = md;
    ifb.auto_reload = ar; ifb.load_val = 4'(lv & 15); ifb.lap = lp;
  endtask

  // Phase knobs (per mille): long stopwatch run, countdown focus, free mix.
  int ph_len [3] = '{1300, 2000, 3000};
  int p_clr  [3] = '{0, 5, 10};
  int p_st   [3] = '{20, 100, 150};
  int p_sp   [3] = '{0, 30, 50};
  int p_lp   [3] = '{50, 100, 100};
  int f_mode [3] = '{0, 1, -1};

  initial begin
    m_t ma, mb;
    bit st, sp, cl, md, ar, lp;
    int lv;

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    ma = m_reset();
    mb = m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_both(ma, mb);
    reset_n = 1'b1;

    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < ph_len[ph]; i++) begin
        @(negedge clk);
        chk_both(ma, mb);
        if (ph == 2 && i == 1500) begin
          drive(0, 0, 0, 0, 0, 0, 0);
          reset_n = 1'b0;
          #1;
          ma = m_reset();
          mb = m_reset();
          chk_both(ma, mb);
          @(negedge clk);
          reset_n = 1'b1;
          continue;
        end
        cl = ($urandom_range(0, 999) < p_clr[ph]);
        st = ($urandom_range(0, 999) < p_st[ph]);
        sp = ($urandom_range(0, 999) < p_sp[ph]);
        lp = ($urandom_range(0, 999) < p_lp[ph]);
        ar = 1'($urandom_range(0, 1));
        md = (f_mode[ph] < 0) ? 1'($urandom_range(0, 1)) : 1'(f_mode[ph]);
        if (ph == 1)                           lv = int'($urandom_range(0, 4));
        else if ($urandom_range(0, 3) == 0)    lv = int'($urandom_range(0, 255));
        else                                   lv = int'($urandom_range(0, 6));
        drive(st, sp, cl, md, ar, lv, lp);
        ma = m_step(ma, 8, 4, st, sp, cl, md, ar, lv, lp);
        mb = m_step(mb, 4, 1, st, sp, cl, md, ar, lv & 15, lp);
      end
    end
    @(negedge clk);
    chk_both(ma, mb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
